riscv_pipectl: RTL and testbench

Central stall/flush sequencer for the five-stage RV64 pipeline. It drives the hold and flush controls of the PC and the FD/DE/EM/MW pipeline registers. Those registers capture when their hold bit is 0, and a flush zeroes them. It resolves load-use, branch-miss, I/D memory stalls, multicycle mul/div waits, trap/xRET redirects and debug halt, and keeps a stall-cycle counter and a mul/div watchdog.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/riscv_pipectl_cnt.sv | 26 ++
 rtl/riscv_pipectl.sv | 165 ++++++++++++++++
 tb/tb_riscv_pipectl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and bit positions for the pipeline stall/flush sequencer.
// The helpers build hold/flush vectors by named stage so callers never hand-pack bits.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MDIV  = 2'd1,
        DMISS = 2'd2,
        TRAP  = 2'd3
    } pipectl_state_e;

    localparam int HOLD_PC = 0;
    localparam int HOLD_FD = 1;
    localparam int HOLD_DE = 2;
    localparam int HOLD_EM = 3;
    localparam int HOLD_MW = 4;

    localparam int FL_FD = 0;
    localparam int FL_DE = 1;
    localparam int FL_EM = 2;
    localparam int FL_MW = 3;

    function automatic logic [4:0] holdBits(input logic mw, input logic em, input logic de,
                                            input logic fd, input logic pc);
        logic [4:0] v;
        v          = '0;
        v[HOLD_MW] = mw;
        v[HOLD_EM] = em;
        v[HOLD_DE] = de;
        v[HOLD_FD] = fd;
        v[HOLD_PC] = pc;
        return v;
    endfunction

    function automatic logic [3:0] flushBits(input logic mw, input logic em, input logic de,
                                             input logic fd);
        logic [3:0] v;
        v        = '0;
        v[FL_MW] = mw;
        v[FL_EM] = em;
        v[FL_DE] = de;
        v[FL_FD] = fd;
        return v;
    endfunction

endpackage

// File: rtl/riscv_pipectl_cnt.sv
// Up-counter that sticks at all-ones; clear wins over enable.
module riscv_pipectl_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_pipectl.sv
// Stall/flush sequencer for the five-stage pipeline: resolves hazards, memory stalls,
// multicycle mul/div, trap redirects and debug halt into per-register hold/flush controls.
module riscv_pipectl
    import riscv_pkg::*;
#(
    parameter int MDIV_TIMEOUT = 128,
    parameter int TRAP_DRAIN   = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_riscv_pipectl_clk,
    input  logic             i_riscv_pipectl_rst,
    input  logic             i_riscv_pipectl_halt,
    input  logic             i_riscv_pipectl_lduse_hz,
    input  logic             i_riscv_pipectl_bjmiss_e,
    input  logic             i_riscv_pipectl_mdstart_e,
    input  logic             i_riscv_pipectl_mddone,
    input  logic             i_riscv_pipectl_istall,
    input  logic             i_riscv_pipectl_dstall,
    input  logic             i_riscv_pipectl_gototrap_m,
    input  logic [1:0]       i_riscv_pipectl_rettrap_m,
    output logic [4:0]       o_riscv_pipectl_hold,
    output logic [3:0]       o_riscv_pipectl_flush,
    output logic             o_riscv_pipectl_mdkill,
    output logic             o_riscv_pipectl_err,
    output logic [CNT_W-1:0] o_riscv_pipectl_stallcnt,
    output logic [1:0]       o_riscv_pipectl_state
);

    localparam int WD_W = 16;
    localparam int DR_W = (TRAP_DRAIN < 2) ? 1 : $clog2(TRAP_DRAIN + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDIV_TIMEOUT - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(TRAP_DRAIN - 1);

    pipectl_state_e r_state;
    pipectl_state_e w_stateNext;
    logic           r_mdFlight;
    logic           w_mdFlightNext;
    logic           r_err;

    logic [4:0]      w_hold;
    logic [3:0]      w_flush;
    logic            w_mdkill;
    logic            w_trap;
    logic            w_mdBusy;
    logic            w_stallEn;
    logic            w_wdEn;
    logic            w_wdClr;
    logic            w_drEn;
    logic            w_drClr;
    logic [WD_W-1:0] w_wdCnt;
    logic [DR_W-1:0] w_drCnt;

    assign w_trap   = i_riscv_pipectl_gototrap_m | (|i_riscv_pipectl_rettrap_m);
    // A mul/div is still owed a result either in MDIV or parked behind a data miss.
    assign w_mdBusy = (r_state == MDIV) || ((r_state == DMISS) && r_mdFlight);

    always_ff @(posedge i_riscv_pipectl_clk or negedge i_riscv_pipectl_rst) begin
        if (!i_riscv_pipectl_rst) begin
            r_state    <= RUN;
            r_mdFlight <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_mdFlight <= w_mdFlightNext;
        end
    end

    always_comb begin
        w_hold         = '0;
        w_flush        = '0;
        w_mdkill       = 1'b0;
        w_stateNext    = r_state;
        w_mdFlightNext = 1'b0;
        w_wdEn         = 1'b0;
        w_wdClr        = 1'b0;
        w_drEn         = 1'b0;
        w_drClr        = 1'b0;

        if (i_riscv_pipectl_halt) begin
            w_hold         = holdBits(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            w_mdFlightNext = r_mdFlight;
        end else if (i_riscv_pipectl_dstall) begin
            w_hold         = holdBits(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            w_flush        = flushBits(1'b1, 1'b0, 1'b0, 1'b0);
            w_stateNext    = DMISS;
            w_mdFlightNext = w_mdBusy && !i_riscv_pipectl_mddone;
        end else if (w_trap) begin
            w_flush     = flushBits(1'b0, 1'b1, 1'b1, 1'b1);
            w_mdkill    = (r_state == MDIV);
            w_stateNext = TRAP;
            w_drClr     = 1'b1;
        end else if (w_mdBusy && !i_riscv_pipectl_mddone) begin
            w_hold      = holdBits(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            w_flush     = flushBits(1'b0, 1'b1, 1'b0, 1'b0);
            w_stateNext = MDIV;
            w_wdEn      = (r_state == MDIV);
        end else begin
            w_stateNext = RUN;
            if (r_state == TRAP) begin
                w_drEn = 1'b1;
                if (w_drCnt != DR_LAST) begin
                    w_stateNext = TRAP;
                end
            end

            if (i_riscv_pipectl_bjmiss_e) begin
                w_flush = flushBits(1'b0, 1'b0, 1'b1, 1'b1);
            end else if (i_riscv_pipectl_mdstart_e && ((r_state == RUN) || (r_state == DMISS))) begin
                w_hold      = holdBits(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                w_flush     = flushBits(1'b0, 1'b1, 1'b0, 1'b0);
                w_stateNext = MDIV;
                w_wdClr     = 1'b1;
            end else if (i_riscv_pipectl_lduse_hz || i_riscv_pipectl_istall) begin
                w_hold  = holdBits(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                w_flush = flushBits(1'b0, 1'b0, 1'b1, 1'b0);
            end

            // Draining after a redirect: FD must take a bubble even if fetch wanted to hold it.
            if (r_state == TRAP) begin
                w_hold[HOLD_FD] = 1'b0;
                w_flush[FL_FD]  = 1'b1;
            end
        end
    end

    assign w_stallEn = w_hold[HOLD_PC] && !i_riscv_pipectl_halt;

    riscv_pipectl_cnt #(.W(CNT_W)) u_stallCnt (
        .i_clk   (i_riscv_pipectl_clk),
        .i_rst_n (i_riscv_pipectl_rst),
        .i_clr   (1'b0),
        .i_en    (w_stallEn),
        .o_cnt   (o_riscv_pipectl_stallcnt)
    );

    riscv_pipectl_cnt #(.W(WD_W)) u_wdCnt (
        .i_clk   (i_riscv_pipectl_clk),
        .i_rst_n (i_riscv_pipectl_rst),
        .i_clr   (w_wdClr),
        .i_en    (w_wdEn),
        .o_cnt   (w_wdCnt)
    );

    riscv_pipectl_cnt #(.W(DR_W)) u_drainCnt (
        .i_clk   (i_riscv_pipectl_clk),
        .i_rst_n (i_riscv_pipectl_rst),
        .i_clr   (w_drClr),
        .i_en    (w_drEn),
        .o_cnt   (w_drCnt)
    );

    always_ff @(posedge i_riscv_pipectl_clk or negedge i_riscv_pipectl_rst) begin
        if (!i_riscv_pipectl_rst) begin
            r_err <= 1'b0;
        end else if (w_wdEn && (w_wdCnt == WD_LAST)) begin
            r_err <= 1'b1;
        end
    end

    assign o_riscv_pipectl_hold   = w_hold & {5{i_riscv_pipectl_rst}};
    assign o_riscv_pipectl_flush  = w_flush & {4{i_riscv_pipectl_rst}};
    assign o_riscv_pipectl_mdkill = w_mdkill & i_riscv_pipectl_rst;
    assign o_riscv_pipectl_err    = r_err;
    assign o_riscv_pipectl_state  = r_state;

endmodule

// File: tb/tb_riscv_pipectl.sv
// Directed bench for riscv_pipectl: a per-cycle vector table plus reset and watchdog sequences.
// A second instance with a short timeout and narrow counter shares the same stimulus.
module tb_riscv_pipectl;

    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [7:0] IST  = 8'h01;
    localparam logic [7:0] LDU  = 8'h02;
    localparam logic [7:0] BJ   = 8'h04;
    localparam logic [7:0] MDS  = 8'h08;
    localparam logic [7:0] MDD  = 8'h10;
    localparam logic [7:0] TRP  = 8'h20;
    localparam logic [7:0] DST  = 8'h40;
    localparam logic [7:0] HLT  = 8'h80;

    typedef struct {
        logic [7:0] in;
        logic [1:0] ret;
        logic [4:0] eHold;
        logic [3:0] eFlush;
        logic       eKill;
        logic [1:0] eState;
        int         eCnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        halt, lduse, bjmiss, mdstart, mddone, istall, dstall, gototrap;
    logic [1:0]  rettrap;
    logic [4:0]  holdA, holdB;
    logic [3:0]  flushA, flushB;
    logic        killA, killB, errA, errB;
    logic [31:0] cntA;
    logic [3:0]  cntB;
    logic [1:0]  stateA, stateB;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    riscv_pipectl dutA (
        .i_riscv_pipectl_clk        (clk),
        .i_riscv_pipectl_rst        (rst),
        .i_riscv_pipectl_halt       (halt),
        .i_riscv_pipectl_lduse_hz   (lduse),
        .i_riscv_pipectl_bjmiss_e   (bjmiss),
        .i_riscv_pipectl_mdstart_e  (mdstart),
        .i_riscv_pipectl_mddone     (mddone),
        .i_riscv_pipectl_istall     (istall),
        .i_riscv_pipectl_dstall     (dstall),
        .i_riscv_pipectl_gototrap_m (gototrap),
        .i_riscv_pipectl_rettrap_m  (rettrap),
        .o_riscv_pipectl_hold       (holdA),
        .o_riscv_pipectl_flush      (flushA),
        .o_riscv_pipectl_mdkill     (killA),
        .o_riscv_pipectl_err        (errA),
        .o_riscv_pipectl_stallcnt   (cntA),
        .o_riscv_pipectl_state      (stateA)
    );

    riscv_pipectl #(.MDIV_TIMEOUT(4), .TRAP_DRAIN(2), .CNT_W(4)) dutB (
        .i_riscv_pipectl_clk        (clk),
        .i_riscv_pipectl_rst        (rst),
        .i_riscv_pipectl_halt       (halt),
        .i_riscv_pipectl_lduse_hz   (lduse),
        .i_riscv_pipectl_bjmiss_e   (bjmiss),
        .i_riscv_pipectl_mdstart_e  (mdstart),
        .i_riscv_pipectl_mddone     (mddone),
        .i_riscv_pipectl_istall     (istall),
        .i_riscv_pipectl_dstall     (dstall),
        .i_riscv_pipectl_gototrap_m (gototrap),
        .i_riscv_pipectl_rettrap_m  (rettrap),
        .o_riscv_pipectl_hold       (holdB),
        .o_riscv_pipectl_flush      (flushB),
        .o_riscv_pipectl_mdkill     (killB),
        .o_riscv_pipectl_err        (errB),
        .o_riscv_pipectl_stallcnt   (cntB),
        .o_riscv_pipectl_state      (stateB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] in, input logic [1:0] ret, input logic [4:0] h,
                                input logic [3:0] f, input logic k, input logic [1:0] s, input int c);
        vec_t v;
        v.in = in; v.ret = ret; v.eHold = h; v.eFlush = f; v.eKill = k; v.eState = s; v.eCnt = c;
        return v;
    endfunction

    task automatic driveInputs(input logic [7:0] in, input logic [1:0] ret);
        halt     = in[7];
        dstall   = in[6];
        gototrap = in[5];
        mddone   = in[4];
        mdstart  = in[3];
        bjmiss   = in[2];
        lduse    = in[1];
        istall   = in[0];
        rettrap  = ret;
    endtask

    // Inputs change just after the rising edge; outputs are compared on the falling edge.
    task automatic applyStimulus(input logic [7:0] in, input logic [1:0] ret);
        @(posedge clk);
        #1;
        driveInputs(in, ret);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Each row is one cycle; expected state/stallcnt are the values visible during that cycle.
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(LDU,         2'b00, 5'b00011, 4'b0010, 0, 0, 0));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(MDS,         2'b00, 5'b00111, 4'b0100, 0, 0, 1));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00111, 4'b0100, 0, 1, 2));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00111, 4'b0100, 0, 1, 3));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00111, 4'b0100, 0, 1, 4));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00111, 4'b0100, 0, 1, 5));
        vecs.push_back(mk(MDD,         2'b00, 5'b00000, 4'b0000, 0, 1, 6));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 6));
        vecs.push_back(mk(MDS,         2'b00, 5'b00111, 4'b0100, 0, 0, 6));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00111, 4'b0100, 0, 1, 7));
        vecs.push_back(mk(TRP,         2'b00, 5'b00000, 4'b0111, 1, 1, 8));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0001, 0, 3, 8));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0001, 0, 3, 8));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 8));
        vecs.push_back(mk(DST | TRP,   2'b00, 5'b01111, 4'b1000, 0, 0, 8));
        vecs.push_back(mk(DST | TRP,   2'b00, 5'b01111, 4'b1000, 0, 2, 9));
        vecs.push_back(mk(DST | TRP,   2'b00, 5'b01111, 4'b1000, 0, 2, 10));
        vecs.push_back(mk(TRP,         2'b00, 5'b00000, 4'b0111, 0, 2, 11));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0001, 0, 3, 11));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0001, 0, 3, 11));
        vecs.push_back(mk(BJ|LDU|IST,  2'b00, 5'b00000, 4'b0011, 0, 0, 11));
        vecs.push_back(mk(IST,         2'b00, 5'b00011, 4'b0010, 0, 0, 11));
        vecs.push_back(mk(IDLE,        2'b01, 5'b00000, 4'b0111, 0, 0, 12));
        vecs.push_back(mk(IDLE,        2'b10, 5'b00000, 4'b0111, 0, 3, 12));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0001, 0, 3, 12));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0001, 0, 3, 12));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 12));
        vecs.push_back(mk(HLT | LDU,   2'b00, 5'b11111, 4'b0000, 0, 0, 12));
        vecs.push_back(mk(HLT | MDS,   2'b00, 5'b11111, 4'b0000, 0, 0, 12));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 12));
        vecs.push_back(mk(MDS,         2'b00, 5'b00111, 4'b0100, 0, 0, 12));
        vecs.push_back(mk(HLT,         2'b00, 5'b11111, 4'b0000, 0, 1, 13));
        vecs.push_back(mk(DST,         2'b00, 5'b01111, 4'b1000, 0, 1, 13));
        vecs.push_back(mk(DST,         2'b00, 5'b01111, 4'b1000, 0, 2, 14));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00111, 4'b0100, 0, 2, 15));
        vecs.push_back(mk(MDD,         2'b00, 5'b00000, 4'b0000, 0, 1, 16));
        vecs.push_back(mk(BJ | MDS,    2'b00, 5'b00000, 4'b0011, 0, 0, 16));
        vecs.push_back(mk(IDLE,        2'b00, 5'b00000, 4'b0000, 0, 0, 16));

        // Reset asserted with hazards active: controls must stay quiet.
        rst = 1'b0;
        driveInputs(LDU | DST | TRP, 2'b11);
        #12;
        checkOutput("reset hold", 32'(holdA), 32'h0);
        checkOutput("reset flush", 32'(flushA), 32'h0);
        checkOutput("reset mdkill", 32'(killA), 32'h0);
        checkOutput("reset state", 32'(stateA), 32'h0);
        checkOutput("reset stallcnt", cntA, 32'h0);
        checkOutput("reset err", 32'(errB), 32'h0);
        driveInputs(IDLE, 2'b00);
        #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].in, vecs[i].ret);
            checkOutput($sformatf("row%0d hold", i), 32'(holdA), 32'(vecs[i].eHold));
            checkOutput($sformatf("row%0d flush", i), 32'(flushA), 32'(vecs[i].eFlush));
            checkOutput($sformatf("row%0d mdkill", i), 32'(killA), 32'(vecs[i].eKill));
            checkOutput($sformatf("row%0d state", i), 32'(stateA), 32'(vecs[i].eState));
            checkOutput($sformatf("row%0d stallcnt", i), cntA, 32'(vecs[i].eCnt));
            checkOutput($sformatf("row%0d stallcnt narrow", i), 32'(cntB),
                        32'((vecs[i].eCnt > 15) ? 15 : vecs[i].eCnt));
        end
        checkOutput("long timeout err clear", 32'(errA), 32'h0);
        checkOutput("short timeout err sticky", 32'(errB), 32'h1);

        // Reset while a mul/div is in flight: back to RUN, no kill pulse, err cleared.
        applyStimulus(MDS, 2'b00);
        applyStimulus(IDLE, 2'b00);
        checkOutput("pre-reset state", 32'(stateA), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("midreset state", 32'(stateA), 32'h0);
        checkOutput("midreset mdkill", 32'(killA), 32'h0);
        checkOutput("midreset hold", 32'(holdA), 32'h0);
        checkOutput("midreset err", 32'(errB), 32'h0);
        checkOutput("midreset stallcnt", cntA, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Watchdog: err appears only after the fourth MDIV cycle of the short-timeout instance.
        applyStimulus(MDS, 2'b00);
        checkOutput("wd start state", 32'(stateA), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(IDLE, 2'b00);
            checkOutput($sformatf("wd cycle%0d state", i), 32'(stateA), 32'h1);
            checkOutput($sformatf("wd cycle%0d err", i), 32'(errB), 32'((i >= 5) ? 1 : 0));
        end
        applyStimulus(MDD, 2'b00);
        checkOutput("wd done hold", 32'(holdA), 32'h0);
        checkOutput("wd done err", 32'(errB), 32'h1);
        applyStimulus(IDLE, 2'b00);
        checkOutput("wd after state", 32'(stateA), 32'h0);
        checkOutput("wd after err", 32'(errB), 32'h1);
        checkOutput("wd after long err", 32'(errA), 32'h0);
        checkOutput("wd after stallcnt", cntA, 32'd6);
        rst = 1'b0;
        #1;
        checkOutput("wd reset err", 32'(errB), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
